// File: rtl/count_capture_unit.sv
// High-order extension of a 4-bit counter with tear-free {hi, low} snapshots handed off over valid/ack.
// Optional define COUNT_CAPTURE_MISS_CNT_EN adds a saturating dropped-request counter (miss_cnt).
module count_capture_unit #(
  parameter int HI_W          = 4,
  parameter bit SNAP_ON_RESET = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              co,
  input  logic [3:0]        counter,
  input  logic              cap_req,
  input  logic              cap_ack,
  input  logic              ovf_clr,
  output logic [HI_W-1:0]   hi_count,
  output logic [HI_W+3:0]   snap_data,
  output logic              snap_valid,
  output logic              ovf,
  output logic              miss,
`ifdef COUNT_CAPTURE_MISS_CNT_EN
  output logic [3:0]        miss_cnt,
`endif
  output logic              dbg_state
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  localparam state_e RST_STATE = SNAP_ON_RESET ? HOLD : IDLE;

  state_e          state_q, state_d;
  logic [HI_W-1:0] hi_count_q, hi_count_d;
  logic [HI_W+3:0] snap_data_q, snap_data_d;
  logic            snap_valid_q, snap_valid_d;
  logic            ovf_q, ovf_d;
  logic            miss_q, miss_d;
  logic            inc;
  logic            wrap;
  logic            miss_ev;
  logic [HI_W+3:0] snap_src;
`ifdef COUNT_CAPTURE_MISS_CNT_EN
  logic [3:0]      miss_cnt_q, miss_cnt_d;
`endif

  assign inc      = en & co;
  assign wrap     = inc & (&hi_count_q);
  // Pre-edge high value paired with pre-edge low value: never torn across a carry.
  assign snap_src = {hi_count_q, counter};

  // Handshake: snap_valid rises the cycle after cap_req is seen in IDLE and stays high with
  // snap_data frozen until a cycle with cap_ack=1; cap_req+cap_ack together relatch a new
  // snapshot without dropping snap_valid; cap_req without cap_ack while held is a miss.
  always_comb begin
    state_d      = state_q;
    snap_data_d  = snap_data_q;
    snap_valid_d = snap_valid_q;
    miss_ev      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cap_req) begin
          snap_data_d  = snap_src;
          snap_valid_d = 1'b1;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (cap_ack && cap_req) begin
          snap_data_d = snap_src;
        end else if (cap_ack) begin
          snap_valid_d = 1'b0;
          state_d      = IDLE;
        end else if (cap_req) begin
          miss_ev = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hi_count_d = inc ? hi_count_q + 1'b1 : hi_count_q;
    if (wrap)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
`ifdef COUNT_CAPTURE_MISS_CNT_EN
    if (miss_ev)      miss_d = 1'b1;
    else if (ovf_clr) miss_d = 1'b0;
    else              miss_d = miss_q;
    if (ovf_clr)                        miss_cnt_d = miss_ev ? 4'd1 : 4'd0;
    else if (miss_ev && !(&miss_cnt_q)) miss_cnt_d = miss_cnt_q + 4'd1;
    else                                miss_cnt_d = miss_cnt_q;
`else
    miss_d = miss_q | miss_ev;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RST_STATE;
      hi_count_q   <= '0;
      snap_data_q  <= '0;
      snap_valid_q <= SNAP_ON_RESET;
      ovf_q        <= 1'b0;
      miss_q       <= 1'b0;
`ifdef COUNT_CAPTURE_MISS_CNT_EN
      miss_cnt_q   <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      hi_count_q   <= hi_count_d;
      snap_data_q  <= snap_data_d;
      snap_valid_q <= snap_valid_d;
      ovf_q        <= ovf_d;
      miss_q       <= miss_d;
`ifdef COUNT_CAPTURE_MISS_CNT_EN
      miss_cnt_q   <= miss_cnt_d;
`endif
    end
  end

  assign hi_count   = hi_count_q;
  assign snap_data  = snap_data_q;
  assign snap_valid = snap_valid_q;
  assign ovf        = ovf_q;
  assign miss       = miss_q;
  assign dbg_state  = (state_q == HOLD);
`ifdef COUNT_CAPTURE_MISS_CNT_EN
  assign miss_cnt   = miss_cnt_q;
`endif

endmodule

// File: tb/tb_count_capture_unit.sv
// Self-checking bench for count_capture_unit: directed scenarios plus a randomized run against a
// timestamp-level reference model (total increment count, snapshot slot, sticky flags).
module tb_count_capture_unit;
  localparam int HI_W = 4;
  localparam int SW   = HI_W + 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0, co = 1'b0, cap_req = 1'b0, cap_ack = 1'b0, ovf_clr = 1'b0;
  logic [3:0]      counter = 4'd0;
  logic [HI_W-1:0] hi_count;
  logic [SW-1:0]   snap_data;
  logic            snap_valid, ovf, miss, dbg_state;
`ifdef COUNT_CAPTURE_MISS_CNT_EN
  logic [3:0]      miss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  int            m_total;
  logic          m_valid, m_ovf, m_miss;
  logic [SW-1:0] m_data;
  int            m_cnt;
  logic [SW-1:0] exp_q[$];

  count_capture_unit #(.HI_W(HI_W), .SNAP_ON_RESET(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .co(co), .counter(counter),
    .cap_req(cap_req), .cap_ack(cap_ack), .ovf_clr(ovf_clr),
    .hi_count(hi_count), .snap_data(snap_data), .snap_valid(snap_valid),
    .ovf(ovf), .miss(miss),
`ifdef COUNT_CAPTURE_MISS_CNT_EN
    .miss_cnt(miss_cnt),
`endif
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [HI_W-1:0] m_hi();
    return HI_W'(m_total % (1 << HI_W));
  endfunction

  task automatic model_reset();
    m_total = 0; m_valid = 1'b0; m_ovf = 1'b0; m_miss = 1'b0; m_data = '0; m_cnt = 0;
  endtask

  // One clock edge: update the model from pre-edge inputs, then move to edge+1.
  task automatic tick();
    logic          inc, miss_ev;
    logic [SW-1:0] src;
    inc     = en && co;
    src     = {m_hi(), counter};
    miss_ev = 1'b0;
    if (!m_valid) begin
      if (cap_req) begin m_valid = 1'b1; m_data = src; end
    end else if (cap_ack) begin
      if (cap_req) m_data = src; else m_valid = 1'b0;
    end else if (cap_req) begin
      miss_ev = 1'b1;
    end
    if (inc && (m_total % (1 << HI_W)) == (1 << HI_W) - 1) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    if (inc) m_total++;
`ifdef COUNT_CAPTURE_MISS_CNT_EN
    if (miss_ev) m_miss = 1'b1; else if (ovf_clr) m_miss = 1'b0;
    if (ovf_clr) m_cnt = miss_ev ? 1 : 0;
    else if (miss_ev && m_cnt < 15) m_cnt++;
`else
    if (miss_ev) m_miss = 1'b1;
`endif
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    en = 0; co = 0; counter = 0; cap_req = 0; cap_ack = 0; ovf_clr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1; #2; rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (hi_count !== '0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi_count); end
    checks++; if (snap_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", snap_valid); end
    checks++; if (snap_data !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", snap_data); end
    checks++; if ({ovf, miss} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {ovf, miss}); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_carry_gating();
    do_reset();
    en = 1;
    for (int i = 0; i < 3; i++) begin
      co = 1; counter = 4'hF; tick();
      co = 0; counter = 4'h0; tick();
    end
    en = 0; co = 1; counter = 4'hF;
    repeat (5) tick();
    checks++; if (hi_count !== 4'd3) begin errors++; $display("FAIL carry_gating got=%h exp=3", hi_count); end
  endtask

  task automatic test_wrap();
    do_reset();
    en = 1; co = 1; counter = 4'hF;
    repeat (16) tick();
    checks++; if ({hi_count, ovf} !== {4'd0, 1'b1}) begin errors++; $display("FAIL wrap16 got=%h/%b exp=0/1", hi_count, ovf); end
    ovf_clr = 1; tick(); ovf_clr = 0;
    checks++; if ({hi_count, ovf} !== {4'd1, 1'b0}) begin errors++; $display("FAIL ovf_clr got=%h/%b exp=1/0", hi_count, ovf); end
    repeat (14) tick();
    ovf_clr = 1; tick(); ovf_clr = 0;
    checks++; if ({hi_count, ovf} !== {4'd0, 1'b1}) begin errors++; $display("FAIL wrap_set_wins got=%h/%b exp=0/1", hi_count, ovf); end
  endtask

  task automatic test_tear_free();
    do_reset();
    en = 1; co = 1; counter = 4'hF;
    repeat (2) tick();
    cap_req = 1; tick(); cap_req = 0; en = 0; co = 0;
    checks++; if (snap_data !== 8'h2F) begin errors++; $display("FAIL tear_free_data got=%h exp=2f", snap_data); end
    checks++; if ({snap_valid, hi_count} !== {1'b1, 4'd3}) begin errors++; $display("FAIL tear_free_hi got=%b/%h exp=1/3", snap_valid, hi_count); end
  endtask

  task automatic test_handshake();
    do_reset();
    counter = 4'h5; cap_req = 1; tick(); cap_req = 0;
    checks++; if ({snap_valid, snap_data} !== {1'b1, 8'h05}) begin errors++; $display("FAIL hs_latch got=%b/%h exp=1/05", snap_valid, snap_data); end
    for (int i = 0; i < 4; i++) begin
      counter = 4'(i + 9); tick();
      checks++; if ({snap_valid, snap_data} !== {1'b1, 8'h05}) begin errors++; $display("FAIL hs_stable got=%b/%h exp=1/05", snap_valid, snap_data); end
    end
    cap_ack = 1; tick();
    checks++; if (snap_valid !== 1'b0) begin errors++; $display("FAIL hs_ack got=%b exp=0", snap_valid); end
    tick(); cap_ack = 0;
    checks++; if ({snap_valid, miss} !== 2'b00) begin errors++; $display("FAIL hs_idle_ack got=%b exp=00", {snap_valid, miss}); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    counter = 4'h1; cap_req = 1; tick();
    counter = 4'h2; tick();
    checks++; if ({miss, snap_data} !== {1'b1, 8'h01}) begin errors++; $display("FAIL b2b_miss got=%b/%h exp=1/01", miss, snap_data); end
    counter = 4'h3; cap_ack = 1; tick(); cap_ack = 0;
    checks++; if ({snap_valid, snap_data} !== {1'b1, 8'h03}) begin errors++; $display("FAIL b2b_relatch got=%b/%h exp=1/03", snap_valid, snap_data); end
`ifdef COUNT_CAPTURE_MISS_CNT_EN
    repeat (19) tick();
    checks++; if (miss_cnt !== 4'hF) begin errors++; $display("FAIL miss_cnt_sat got=%h exp=f", miss_cnt); end
    ovf_clr = 1; tick(); ovf_clr = 0;
    checks++; if ({miss, miss_cnt} !== {1'b1, 4'd1}) begin errors++; $display("FAIL miss_clr_race got=%b/%h exp=1/1", miss, miss_cnt); end
`endif
    cap_req = 0;
  endtask

  task automatic test_random();
    logic [3:0] lo;
    do_reset();
    lo = 4'($urandom_range(0, 15));
    for (int i = 0; i < 400; i++) begin
      en      = ($urandom_range(0, 3) != 0);
      counter = lo; co = (lo == 4'hF);
      cap_req = ($urandom_range(0, 2) == 0);
      cap_ack = ($urandom_range(0, 2) == 0);
      ovf_clr = ($urandom_range(0, 15) == 0);
      if (en) lo = lo + 4'd1;
      tick();
      if (m_valid) exp_q.push_back(m_data);
      checks++;
      if ({hi_count, ovf, miss, snap_valid} !== {m_hi(), m_ovf, m_miss, m_valid}) begin
        errors++;
        $display("FAIL rand_state cyc=%0d got hi=%h ovf=%b miss=%b v=%b exp hi=%h ovf=%b miss=%b v=%b",
                 i, hi_count, ovf, miss, snap_valid, m_hi(), m_ovf, m_miss, m_valid);
      end
      if (snap_valid && exp_q.size() > 0) begin
        checks++;
        if (snap_data !== exp_q[$]) begin errors++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", i, snap_data, exp_q[$]); end
      end
`ifdef COUNT_CAPTURE_MISS_CNT_EN
      checks++;
      if (miss_cnt !== 4'(m_cnt)) begin errors++; $display("FAIL rand_miss_cnt cyc=%0d got=%h exp=%h", i, miss_cnt, m_cnt); end
`endif
    end
    exp_q.delete();
    idle_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1; co = 1; counter = 4'hF;
    repeat (17) tick();
    en = 0; co = 0; counter = 4'h7; cap_req = 1;
    repeat (2) tick();
    cap_req = 0;
    checks++; if ({snap_valid, ovf, miss, hi_count} !== {3'b111, 4'd1}) begin errors++; $display("FAIL pre_async got=%b%b%b/%h exp=111/1", snap_valid, ovf, miss, hi_count); end
    #3 rst = 1'b1;
    #1;
    checks++; if ({snap_valid, ovf, miss, hi_count} !== {3'b000, 4'd0}) begin errors++; $display("FAIL async_reset got=%b%b%b/%h exp=000/0", snap_valid, ovf, miss, hi_count); end
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    test_reset();
    test_carry_gating();
    test_wrap();
    test_tear_free();
    test_handshake();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
